// File: rtl/pin_serializer_if.sv
// Parallel-word feed into pin_serializer: valid/ready handshake carrying one WIDTH-bit word.
interface pin_serializer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, in_data, input in_ready);
  modport slave  (input in_valid, in_data, output in_ready);
endinterface

// File: rtl/pin_serializer.sv
// Buffers parallel words in a small FIFO and shifts each out one bit per clock
// (ser_bit -> z pin, ser_en -> y pin), counting completed words on frame_cnt.
module pin_serializer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int GAP       = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  pin_serializer_if.slave feed,
  output logic            ser_bit,
  output logic            ser_en,
  output logic            busy,
  output logic [31:0]     frame_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH-1);
  localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP-1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             empty, full, push, load, last_bit;
  logic [WIDTH-1:0] head;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bitcnt;
  logic [GW-1:0]    gapcnt;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign empty         = (count == '0);
  assign full          = (count == FULL_CNT);
  assign feed.in_ready = !full;
  assign push          = feed.in_valid && !full;
  assign head          = mem[rd_ptr];
  assign last_bit      = (state == S_SHIFT) && (bitcnt == '0);
  assign busy          = (state != S_IDLE) || !empty;

  always_comb begin
    // NOTE: default assigned first so no path leaves load unassigned (no latch).
    load = 1'b0;
    if (!empty) begin
      case (state)
        S_IDLE:  load = 1'b1;
        S_SHIFT: load = (bitcnt == '0) && (GAP == 0);
        S_GAP:   load = (gapcnt == '0);
        default: load = 1'b0;
      endcase
    end
  end

  // NOTE: storage array has no reset; occupancy and pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= feed.in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      case ({push, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      gapcnt    <= '0;
      ser_bit   <= 1'b0;
      ser_en    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (last_bit) frame_cnt <= frame_cnt + 32'd1;

      case (state)
        S_SHIFT: begin
          if (bitcnt != '0) begin
            ser_bit <= first_bit(shreg);
            shreg   <= shifted(shreg);
            bitcnt  <= bitcnt - 1'b1;
          end else begin
            ser_en  <= 1'b0;
            ser_bit <= 1'b0;
            if (GAP > 0) begin
              state  <= S_GAP;
              gapcnt <= GAP_LOAD;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (gapcnt != '0) gapcnt <= gapcnt - 1'b1;
          else              state  <= S_IDLE;
        end
        default: ;
      endcase

      // A load overrides the fall-back transitions above, so queued words follow with no bubble.
      if (load) begin
        state   <= S_SHIFT;
        shreg   <= shifted(head);
        ser_bit <= first_bit(head);
        ser_en  <= 1'b1;
        bitcnt  <= LAST_IDX;
      end
    end
  end

endmodule

// File: tb/tb_pin_serializer.sv
// Directed bench for pin_serializer: three instances cover MSB-first/GAP=1,
// LSB-first/GAP=1 and MSB-first/GAP=0; a negedge monitor reassembles serial words.
module tb_pin_serializer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pin_serializer_if #(.WIDTH(8)) if_a ();
  pin_serializer_if #(.WIDTH(8)) if_b ();
  pin_serializer_if #(.WIDTH(8)) if_c ();

  logic        ser_bit_a, ser_en_a, busy_a;
  logic        ser_bit_b, ser_en_b, busy_b;
  logic        ser_bit_c, ser_en_c, busy_c;
  logic [31:0] frame_a, frame_b, frame_c;

  pin_serializer #(.WIDTH(8), .DEPTH(4), .GAP(1), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .reset(reset), .feed(if_a),
    .ser_bit(ser_bit_a), .ser_en(ser_en_a), .busy(busy_a), .frame_cnt(frame_a));
  pin_serializer #(.WIDTH(8), .DEPTH(4), .GAP(1), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .reset(reset), .feed(if_b),
    .ser_bit(ser_bit_b), .ser_en(ser_en_b), .busy(busy_b), .frame_cnt(frame_b));
  pin_serializer #(.WIDTH(8), .DEPTH(4), .GAP(0), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .reset(reset), .feed(if_c),
    .ser_bit(ser_bit_c), .ser_en(ser_en_c), .busy(busy_c), .frame_cnt(frame_c));

  int errors = 0;
  int checks = 0;
  int stray  = 0;

  logic [7:0] acc_a, acc_b, acc_c;
  int         nb_a, nb_b, nb_c;
  logic [7:0] rx_a[$];
  logic [7:0] rx_b[$];
  logic [7:0] rx_c[$];

  // Serial receiver: rebuilds words in the order each instance shifts them.
  always @(negedge clk) begin
    if (reset) begin
      nb_a = 0; nb_b = 0; nb_c = 0;
    end else begin
      if (ser_en_a) begin
        acc_a = {acc_a[6:0], ser_bit_a}; nb_a++;
        if (nb_a == 8) begin rx_a.push_back(acc_a); nb_a = 0; end
      end else if (ser_bit_a) stray++;
      if (ser_en_b) begin
        acc_b = {ser_bit_b, acc_b[7:1]}; nb_b++;
        if (nb_b == 8) begin rx_b.push_back(acc_b); nb_b = 0; end
      end else if (ser_bit_b) stray++;
      if (ser_en_c) begin
        acc_c = {acc_c[6:0], ser_bit_c}; nb_c++;
        if (nb_c == 8) begin rx_c.push_back(acc_c); nb_c = 0; end
      end else if (ser_bit_c) stray++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    if_a.in_valid = 1'b0; if_a.in_data = '0;
    if_b.in_valid = 1'b0; if_b.in_data = '0;
    if_c.in_valid = 1'b0; if_c.in_data = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rx_a.delete(); rx_b.delete(); rx_c.delete();
  endtask

  task automatic test_reset;
    if_a.in_valid = 1'b0; if_b.in_valid = 1'b0; if_c.in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", if_a.in_ready); end
    checks++; if (ser_en_a !== 1'b0) begin errors++; $display("FAIL rst_ser_en: got %b expected 0", ser_en_a); end
    checks++; if (ser_bit_a !== 1'b0) begin errors++; $display("FAIL rst_ser_bit: got %b expected 0", ser_bit_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy_a); end
    checks++; if (frame_a !== 32'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d expected 0", frame_a); end
    checks++; if (ser_en_c !== 1'b0 || if_c.in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_c_outputs: got en=%b ready=%b expected en=0 ready=1", ser_en_c, if_c.in_ready);
    end
    do_reset;
  endtask

  task automatic test_msb_first;
    logic [7:0] w;
    w = 8'hA5;
    do_reset;
    if_a.in_valid = 1'b1; if_a.in_data = w;
    tick;
    if_a.in_valid = 1'b0;
    checks++; if (ser_en_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++; $display("FAIL t1_accept_edge: got en=%b busy=%b expected en=0 busy=1", ser_en_a, busy_a);
    end
    for (int i = 0; i < 8; i++) begin
      tick;
      checks++; if (ser_en_a !== 1'b1) begin errors++; $display("FAIL t1_en bit%0d: got %b expected 1", i, ser_en_a); end
      checks++; if (ser_bit_a !== w[7-i]) begin errors++; $display("FAIL t1_bit bit%0d: got %b expected %b", i, ser_bit_a, w[7-i]); end
    end
    tick;
    checks++; if (ser_en_a !== 1'b0 || ser_bit_a !== 1'b0) begin
      errors++; $display("FAIL t1_gap_outputs: got en=%b bit=%b expected 0 0", ser_en_a, ser_bit_a);
    end
    checks++; if (frame_a !== 32'd1) begin errors++; $display("FAIL t1_frame_cnt: got %0d expected 1", frame_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL t1_busy_in_gap: got %b expected 1", busy_a); end
    tick;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL t1_busy_after_gap: got %b expected 0", busy_a); end
    checks++; if (rx_a.size() != 1 || rx_a[0] !== w) begin
      errors++; $display("FAIL t1_rx_word: got size=%0d expected one word %h", rx_a.size(), w);
    end
  endtask

  task automatic test_lsb_first;
    logic [7:0] w;
    w = 8'hA5;
    do_reset;
    if_b.in_valid = 1'b1; if_b.in_data = w;
    tick;
    if_b.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      checks++; if (ser_en_b !== 1'b1) begin errors++; $display("FAIL t2_en bit%0d: got %b expected 1", i, ser_en_b); end
      checks++; if (ser_bit_b !== w[i]) begin errors++; $display("FAIL t2_bit bit%0d: got %b expected %b", i, ser_bit_b, w[i]); end
    end
    tick;
    checks++; if (ser_en_b !== 1'b0) begin errors++; $display("FAIL t2_en_after: got %b expected 0", ser_en_b); end
    checks++; if (frame_b !== 32'd1) begin errors++; $display("FAIL t2_frame_cnt: got %0d expected 1", frame_b); end
  endtask

  task automatic test_gap_pattern;
    logic [7:0] w3 [3];
    logic       exp_en, exp_bit;
    w3 = '{8'hFF, 8'h00, 8'hFF};
    do_reset;
    if_a.in_valid = 1'b1; if_a.in_data = w3[0];
    tick;
    for (int k = 0; k < 27; k++) begin
      if (k == 0)      if_a.in_data = w3[1];
      else if (k == 1) if_a.in_data = w3[2];
      else             if_a.in_valid = 1'b0;
      tick;
      exp_en  = (k % 9) < 8;
      exp_bit = exp_en ? w3[k/9][7 - (k % 9)] : 1'b0;
      checks++; if (ser_en_a !== exp_en || ser_bit_a !== exp_bit) begin
        errors++; $display("FAIL t3_pattern cyc%0d: got en=%b bit=%b expected en=%b bit=%b", k, ser_en_a, ser_bit_a, exp_en, exp_bit);
      end
    end
    checks++; if (frame_a !== 32'd3) begin errors++; $display("FAIL t3_frame_cnt: got %0d expected 3", frame_a); end
    checks++; if (rx_a.size() != 3) begin errors++; $display("FAIL t3_rx_count: got %0d expected 3", rx_a.size()); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] w [6];
    int idx, bubbles, reassert_n;
    logic acc;
    w = '{8'h11, 8'h2E, 8'h3C, 8'h4B, 8'h5A, 8'h69};
    idx = 0; bubbles = 0; reassert_n = -1;
    do_reset;
    if_c.in_valid = 1'b1; if_c.in_data = w[0];
    for (int n = 0; n < 52; n++) begin
      acc = if_c.in_valid && if_c.in_ready;
      tick;
      if (acc) begin
        idx++;
        if (idx < 6) if_c.in_data = w[idx];
        else         if_c.in_valid = 1'b0;
      end
      if (n == 4) begin
        checks++; if (idx != 5 || if_c.in_ready !== 1'b0) begin
          errors++; $display("FAIL t4_fill: got accepted=%0d ready=%b expected 5 0", idx, if_c.in_ready);
        end
      end
      if (n > 4 && reassert_n < 0 && if_c.in_ready === 1'b1) reassert_n = n;
      if (n >= 1 && n <= 48 && ser_en_c !== 1'b1) bubbles++;
      if (n == 49) begin
        checks++; if (ser_en_c !== 1'b0) begin errors++; $display("FAIL t4_en_end: got %b expected 0", ser_en_c); end
      end
    end
    checks++; if (reassert_n != 9) begin errors++; $display("FAIL t4_ready_reassert: got edge %0d expected 9", reassert_n); end
    checks++; if (bubbles != 0) begin errors++; $display("FAIL t4_bubbles: got %0d expected 0", bubbles); end
    checks++; if (frame_c !== 32'd6) begin errors++; $display("FAIL t4_frame_cnt: got %0d expected 6", frame_c); end
    checks++; if (rx_c.size() != 6) begin errors++; $display("FAIL t4_rx_count: got %0d expected 6", rx_c.size()); end
    for (int i = 0; i < 6 && i < rx_c.size(); i++) begin
      checks++; if (rx_c[i] !== w[i]) begin errors++; $display("FAIL t4_rx_word%0d: got %h expected %h", i, rx_c[i], w[i]); end
    end
  endtask

  task automatic test_reset_mid_word;
    int en_high;
    en_high = 0;
    do_reset;
    if_a.in_valid = 1'b1; if_a.in_data = 8'hC3;
    tick;
    if_a.in_data = 8'h5A;
    tick;
    if_a.in_data = 8'h3C;
    tick;
    if_a.in_valid = 1'b0;
    tick;
    checks++; if (ser_en_a !== 1'b1 || ser_bit_a !== 1'b0) begin
      errors++; $display("FAIL t5_third_bit: got en=%b bit=%b expected 1 0", ser_en_a, ser_bit_a);
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (ser_en_a !== 1'b0) begin errors++; $display("FAIL t5_en_drop: got %b expected 0", ser_en_a); end
    checks++; if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL t5_in_ready: got %b expected 1", if_a.in_ready); end
    checks++; if (frame_a !== 32'd0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL t5_frame_busy: got frame=%0d busy=%b expected 0 0", frame_a, busy_a);
    end
    tick;
    tick;
    reset = 1'b0;
    rx_a.delete();
    repeat (20) begin
      tick;
      if (ser_en_a === 1'b1) en_high++;
    end
    checks++; if (en_high != 0 || rx_a.size() != 0) begin
      errors++; $display("FAIL t5_no_output: got en_cycles=%0d words=%0d expected 0 0", en_high, rx_a.size());
    end
    checks++; if (frame_a !== 32'd0) begin errors++; $display("FAIL t5_frame_after: got %0d expected 0", frame_a); end
  endtask

  task automatic test_push_pop_same;
    logic [7:0] w [6];
    w = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hE7, 8'h5A};
    do_reset;
    if_a.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_a.in_data = w[i];
      tick;
    end
    if_a.in_valid = 1'b0;
    checks++; if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL t6_ready_at3: got %b expected 1", if_a.in_ready); end
    repeat (6) tick;
    if_a.in_valid = 1'b1; if_a.in_data = w[4];
    tick;
    checks++; if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL t6_ready_pushpop: got %b expected 1", if_a.in_ready); end
    if_a.in_data = w[5];
    tick;
    if_a.in_valid = 1'b0;
    checks++; if (if_a.in_ready !== 1'b0) begin errors++; $display("FAIL t6_ready_full: got %b expected 0", if_a.in_ready); end
    repeat (60) tick;
    checks++; if (frame_a !== 32'd6) begin errors++; $display("FAIL t6_frame_cnt: got %0d expected 6", frame_a); end
    checks++; if (rx_a.size() != 6) begin errors++; $display("FAIL t6_rx_count: got %0d expected 6", rx_a.size()); end
    for (int i = 0; i < 6 && i < rx_a.size(); i++) begin
      checks++; if (rx_a[i] !== w[i]) begin errors++; $display("FAIL t6_rx_word%0d: got %h expected %h", i, rx_a[i], w[i]); end
    end
  endtask

  initial begin
    test_reset;
    test_msb_first;
    test_lsb_first;
    test_gap_pattern;
    test_back_to_back;
    test_reset_mid_word;
    test_push_pop_same;
    checks++; if (stray != 0) begin errors++; $display("FAIL ser_bit_outside_en: got %0d cycles expected 0", stray); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
